// File: rtl/fibonacci_seq.sv
// Iterative Fibonacci engine: one addition per clock from two seed terms,
// result s(n+2) returned over a valid/ready handshake with overflow flag.
module fibonacci_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_W      = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  input  logic [DATA_W-1:0] seed_a,
  input  logic [DATA_W-1:0] seed_b,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic              overflow
);

  localparam int unsigned SUM_W = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] prev, prev_nxt;
  logic [DATA_W-1:0] cur, cur_nxt;
  logic [N_W-1:0]    cnt, cnt_nxt;
  logic [N_W-1:0]    n_r, n_r_nxt;
  logic              ovf, ovf_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              overflow_nxt;
  logic              in_ready_nxt;
  logic              out_valid_nxt;
  logic [SUM_W-1:0]  sum;
  logic              ovf_add;
  logic [DATA_W-1:0] cur_add;

  // State and datapath registers; handshake flags are registered copies of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      cur       <= '0;
      cnt       <= '0;
      n_r       <= '0;
      ovf       <= 1'b0;
      data      <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      n_r       <= n_r_nxt;
      ovf       <= ovf_nxt;
      data      <= data_nxt;
      overflow  <= overflow_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    cur_nxt      = cur;
    cnt_nxt      = cnt;
    n_r_nxt      = n_r;
    ovf_nxt      = ovf;
    data_nxt     = data;
    overflow_nxt = overflow;

    sum     = SUM_W'(prev) + SUM_W'(cur);
    ovf_add = ovf | sum[DATA_W];
    // Saturation is sticky: once overflowed, every later term is clamped
    cur_add = ((SATURATE != 0) && ovf_add) ? '1 : sum[DATA_W-1:0];

    unique case (state)
      IDLE: begin
        if (start) begin
          prev_nxt  = seed_a;
          cur_nxt   = seed_b;
          cnt_nxt   = '0;
          n_r_nxt   = n;
          ovf_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        prev_nxt = cur;
        cur_nxt  = cur_add;
        ovf_nxt  = ovf_add;
        // Equality compare lets the maximum index fit the counter width
        if (cnt == n_r) begin
          data_nxt     = cur_add;
          overflow_nxt = ovf_add;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt + N_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Self-checking bench for fibonacci_seq: wrap and saturate variants with an
// 8-bit index, plus a 4-bit index instance for the small-counter boundary.
module tb_fibonacci_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  n;
  logic [31:0] seed_a, seed_b;
  logic        out_ready;
  logic        start4;

  logic ir_w, ov_w, of_w, ir_s, ov_s, of_s, ir_4, ov_4, of_4;
  logic [31:0] d_w, d_s, d_4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // The 4-bit-index instance only sees requests whose index fits it
  assign start4 = start && (n < 8'd16);

  fibonacci_seq #(.DATA_W(32), .N_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .n(n), .seed_a(seed_a), .seed_b(seed_b),
    .in_ready(ir_w), .out_valid(ov_w), .out_ready(out_ready), .data(d_w), .overflow(of_w));

  fibonacci_seq #(.DATA_W(32), .N_W(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .n(n), .seed_a(seed_a), .seed_b(seed_b),
    .in_ready(ir_s), .out_valid(ov_s), .out_ready(out_ready), .data(d_s), .overflow(of_s));

  fibonacci_seq #(.DATA_W(32), .N_W(4), .SATURATE(0)) u_n4 (
    .clk(clk), .reset(reset), .start(start4), .n(n[3:0]), .seed_a(seed_a), .seed_b(seed_b),
    .in_ready(ir_4), .out_valid(ov_4), .out_ready(out_ready), .data(d_4), .overflow(of_4));

  // Reference: iterate the recurrence with 64-bit arithmetic; {overflow, result}
  function automatic logic [32:0] fib_ref(input logic [31:0] a, input logic [31:0] b,
                                          input int nn, input bit sat);
    longint unsigned x, y, s;
    bit o;
    x = 64'(a);
    y = 64'(b);
    o = 1'b0;
    for (int k = 0; k <= nn; k++) begin
      s = x + y;
      if (s > 64'hFFFF_FFFF) o = 1'b1;
      x = y;
      y = s & 64'hFFFF_FFFF;
    end
    if (sat && o) y = 64'hFFFF_FFFF;
    return {o, y[31:0]};
  endfunction

  // Issue one request and wait for out_valid; lat = -1 if it never arrives
  task automatic do_request(input logic [31:0] a, input logic [31:0] b, input logic [7:0] nn,
                            input logic hold_rdy, output int lat,
                            output logic ir_before, output logic ir_after);
    @(negedge clk);
    out_ready = hold_rdy;
    start     = 1'b1;
    n         = nn;
    seed_a    = a;
    seed_b    = b;
    ir_before = ir_w;
    @(posedge clk);
    #1 ir_after = ir_w;
    @(negedge clk);
    start  = 1'b0;
    n      = 8'($urandom);
    seed_a = $urandom;
    seed_b = $urandom;
    lat    = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      #1;
      if (ov_w) break;
    end
    if (!ov_w) lat = -1;
  endtask

  task automatic drain(output logic ov_after, output logic ir_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    ov_after = ov_w;
    ir_after = ir_w;
  endtask

  task automatic test_reset;
    total++;
    if ({ir_w, ov_w, d_w, of_w} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_wrap: got ir=%b ov=%b d=%h of=%b want ir=1 ov=0 d=0 of=0", ir_w, ov_w, d_w, of_w);
    end
    total++;
    if ({ir_s, ov_s, d_s, of_s, ir_4, ov_4, d_4, of_4} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_sat_n4: got ir=%b ov=%b d=%h of=%b / ir=%b ov=%b d=%h of=%b want idle zeros",
               ir_s, ov_s, d_s, of_s, ir_4, ov_4, d_4, of_4);
    end
  endtask

  // Consumer ready before the result exists: exactly n+1 cycles, then immediate transfer
  task automatic test_early_ready;
    int lat;
    logic irb, ira;
    do_request(32'd0, 32'd1, 8'd5, 1'b1, lat, irb, ira);
    total++;
    if (lat !== 6 || d_w !== 32'd13 || of_w !== 1'b0 || ov_4 !== 1'b1 || d_4 !== 32'd13) begin
      bad++;
      $display("FAIL early_ready: got lat=%0d d=%0d of=%b ov4=%b d4=%0d want lat=6 d=13 of=0 ov4=1 d4=13",
               lat, d_w, of_w, ov_4, d_4);
    end
    @(posedge clk);
    #1;
    total++;
    if (ov_w !== 1'b0 || ir_w !== 1'b1 || ir_4 !== 1'b1) begin
      bad++;
      $display("FAIL early_ready_xfer: got ov=%b ir=%b ir4=%b want ov=0 ir=1 ir4=1", ov_w, ir_w, ir_4);
    end
  endtask

  // Directed boundary cases followed by random requests
  task automatic test_sequences;
    logic [31:0] qa[$], qb[$];
    int          qn[$];
    logic [32:0] ew, es;
    int lat;
    logic irb, ira, ova, ira2;
    qa = '{32'd3, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'd0};
    qb = '{32'd4, 32'd1, 32'd1, 32'd1, 32'h8000_0000, 32'd1};
    qn = '{0, 15, 45, 46, 0, 255};
    for (int i = 0; i < 10; i++) begin
      qa.push_back($urandom);
      qb.push_back($urandom >> $urandom_range(0, 31));
      qn.push_back(int'($urandom_range(0, 63)));
    end
    for (int i = 0; i < qn.size(); i++) begin
      ew = fib_ref(qa[i], qb[i], qn[i], 1'b0);
      es = fib_ref(qa[i], qb[i], qn[i], 1'b1);
      do_request(qa[i], qb[i], 8'(qn[i]), 1'b0, lat, irb, ira);
      total++;
      if (lat !== qn[i] + 1 || irb !== 1'b1 || ira !== 1'b0) begin
        bad++;
        $display("FAIL seq%0d_timing: got lat=%0d ir_before=%b ir_after=%b want lat=%0d 1 0",
                 i, lat, irb, ira, qn[i] + 1);
      end
      total++;
      if ({of_w, d_w} !== ew) begin
        bad++;
        $display("FAIL seq%0d_wrap: got of=%b d=%h want of=%b d=%h", i, of_w, d_w, ew[32], ew[31:0]);
      end
      total++;
      if ({ov_s, of_s, d_s} !== {1'b1, es}) begin
        bad++;
        $display("FAIL seq%0d_sat: got ov=%b of=%b d=%h want ov=1 of=%b d=%h", i, ov_s, of_s, d_s, es[32], es[31:0]);
      end
      if (qn[i] < 16) begin
        total++;
        if ({ov_4, of_4, d_4} !== {1'b1, ew}) begin
          bad++;
          $display("FAIL seq%0d_n4: got ov=%b of=%b d=%h want ov=1 of=%b d=%h", i, ov_4, of_4, d_4, ew[32], ew[31:0]);
        end
      end
      drain(ova, ira2);
      total++;
      if (ova !== 1'b0 || ira2 !== 1'b1) begin
        bad++;
        $display("FAIL seq%0d_xfer: got ov=%b ir=%b want ov=0 ir=1", i, ova, ira2);
      end
    end
  endtask

  // Hold DONE under backpressure while hammering start; nothing may change
  task automatic test_backpressure;
    int lat;
    logic irb, ira;
    logic [31:0] hold_d;
    logic hold_o;
    do_request(32'd0, 32'd1, 8'd46, 1'b0, lat, irb, ira);
    hold_d = d_w;
    hold_o = of_w;
    total++;
    if (lat !== 47 || hold_d !== 32'd512559680 || hold_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_result: got lat=%0d d=%0d of=%b want lat=47 d=512559680 of=1", lat, hold_d, hold_o);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start  = 1'b1;
      n      = 8'($urandom);
      seed_a = $urandom;
      seed_b = $urandom;
      @(posedge clk);
      #1;
      total++;
      if ({ov_w, ir_w, d_w, of_w, d_s} !== {1'b1, 1'b0, hold_d, hold_o, 32'hFFFF_FFFF}) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b d=%h of=%b ds=%h want ov=1 ir=0 d=%h of=%b ds=ffffffff",
                 c, ov_w, ir_w, d_w, of_w, d_s, hold_d, hold_o);
      end
    end
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ov_w !== 1'b0 || ir_w !== 1'b1) begin
      bad++;
      $display("FAIL bp_xfer: got ov=%b ir=%b want ov=0 ir=1", ov_w, ir_w);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ov_w, ir_w, d_w, of_w} !== {1'b0, 1'b1, hold_d, hold_o}) begin
      bad++;
      $display("FAIL bp_retain: got ov=%b ir=%b d=%h of=%b want ov=0 ir=1 d=%h of=%b",
               ov_w, ir_w, d_w, of_w, hold_d, hold_o);
    end
  endtask

  // Reset three cycles into a run, then a clean n=2 request
  task automatic test_reset_mid;
    int lat;
    logic irb, ira, ova, ira2;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b1;
    n         = 8'd10;
    seed_a    = 32'd0;
    seed_b    = 32'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({ir_w, ov_w, d_w, of_w, ir_s, ov_s, d_s} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_mid: got ir=%b ov=%b d=%h of=%b irs=%b ovs=%b ds=%h want 1 0 0 0 1 0 0",
               ir_w, ov_w, d_w, of_w, ir_s, ov_s, d_s);
    end
    @(negedge clk);
    reset = 1'b0;
    do_request(32'd0, 32'd1, 8'd2, 1'b0, lat, irb, ira);
    total++;
    if (lat !== 3 || d_w !== 32'd3 || of_w !== 1'b0 || d_4 !== 32'd3) begin
      bad++;
      $display("FAIL reset_mid_rerun: got lat=%0d d=%0d of=%b d4=%0d want lat=3 d=3 of=0 d4=3", lat, d_w, of_w, d_4);
    end
    drain(ova, ira2);
    total++;
    if (ova !== 1'b0 || ira2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_xfer: got ov=%b ir=%b want ov=0 ir=1", ova, ira2);
    end
  endtask

  // Reset and start together: the start is dropped
  task automatic test_reset_start;
    @(negedge clk);
    out_ready = 1'b0;
    reset     = 1'b1;
    start     = 1'b1;
    n         = 8'd1;
    seed_a    = 32'd5;
    seed_b    = 32'd6;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({ir_w, ov_w, d_w, ir_4, ov_4} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_start: got ir=%b ov=%b d=%h ir4=%b ov4=%b want ir=1 ov=0 d=0 ir4=1 ov4=0",
               ir_w, ov_w, d_w, ir_4, ov_4);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    n         = '0;
    seed_a    = '0;
    seed_b    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    reset = 1'b0;
    test_early_ready;
    test_sequences;
    test_backpressure;
    test_reset_mid;
    test_reset_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
